// File: rtl/regfile_sb_pkg.sv
// Shared types and defaults for the scoreboarded register file and its clear engine.
package regfile_sb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEF_DW     = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 2;
    localparam int ADDR_ZERO  = 0;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: sweeps every register address once, one per cycle, while busy.
//
// state | meaning
// IDLE  | normal operation, writes and pending updates allowed
// CLEAR | sweeping counter across the array, writing zero each cycle
module regfile_clear_fsm
    import regfile_sb_pkg::*;
#(
    parameter int   DEPTH = DEF_DEPTH,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          idle,
    output logic          clr_start,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_start = 1'b0;
        clr_we    = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                    clr_start = 1'b1;
                end
            end
            CLEAR: begin
                clr_we  = 1'b1;
                cnt_nxt = cnt + AW'(1);
                if (cnt == AW'(DEPTH - 1))
                    state_nxt = IDLE;
            end
        endcase
    end

    // Busy is the state flop itself, so it is registered and glitch-free.
    assign clr_busy = (state == CLEAR);
    assign idle     = (state == IDLE);
    assign clr_addr = cnt;

endmodule

// File: rtl/param_regfile_sb.sv
// Parametrised register file with hardwired r0, per-register pending bits and bulk clear.
// Define REGFILE_BYPASS_EN to forward a committing write to same-address reads in the same cycle.
module param_regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int   DW     = DEF_DW,
    parameter int   DEPTH  = DEF_DEPTH,
    parameter int   NUM_RD = DEF_NUM_RD,
    localparam int  AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 pend_set,
    input  logic [AW-1:0]        pend_addr,
    output logic [DEPTH-1:0]     pend_vec,
    input  logic                 clr_req,
    output logic                 clr_busy
);

    logic [DW-1:0] mem [DEPTH];
    logic          idle, clr_start, clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_commit, pend_commit;

    regfile_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .idle      (idle),
        .clr_start (clr_start),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign wr_commit   = wr_en    && idle && (wr_addr   != AW'(ADDR_ZERO));
    assign pend_commit = pend_set && idle && (pend_addr != AW'(ADDR_ZERO));

    // Sweep writes and normal writes are mutually exclusive by FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_commit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Set is applied after clear so a new producer supersedes a same-address writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vec <= '0;
        end else if (clr_start) begin
            pend_vec <= '0;
        end else begin
            if (wr_commit)
                pend_vec[wr_addr] <= 1'b0;
            if (pend_commit)
                pend_vec[pend_addr] <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rv;

        assign ra = rd_addr[g*AW +: AW];

        always_comb begin
            rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_commit && (ra == wr_addr))
                rv = wr_data;
`else
`endif
            if (ra == AW'(ADDR_ZERO))
                rv = '0;
        end

        assign rd_data[g*DW +: DW] = rv;
    end

endmodule

// File: tb/tb_param_regfile_sb.sv
// Scoreboard bench for param_regfile_sb: default 32x32x2 instance plus a 64x16x4 instance.
module tb_param_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [9:0]   rd_addr;
    logic [63:0]  rd_data;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         pend_set;
    logic [4:0]   pend_addr;
    logic [31:0]  pend_vec;
    logic         clr_req, clr_busy;

    logic [15:0]  rd_addr4;
    logic [255:0] rd_data4;
    logic         wr_en4;
    logic [3:0]   wr_addr4;
    logic [63:0]  wr_data4;
    logic         pend_set4;
    logic [3:0]   pend_addr4;
    logic [15:0]  pend_vec4;
    logic         clr_req4, clr_busy4;

    param_regfile_sb #(.DW(32), .DEPTH(32), .NUM_RD(2)) u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr), .pend_vec(pend_vec),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    param_regfile_sb #(.DW(64), .DEPTH(16), .NUM_RD(4)) u_dut4 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .pend_set(pend_set4), .pend_addr(pend_addr4), .pend_vec(pend_vec4),
        .clr_req(clr_req4), .clr_busy(clr_busy4)
    );

    typedef struct {
        bit          wide;
        int          port;
        int          addr;
        logic [63:0] exp;
    } rd_exp_t;

    rd_exp_t     sb[$];
    logic [31:0] m32 [32];
    logic [63:0] m64 [16];
    logic [31:0] mp;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cnt;
    logic [31:0] exp32;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input bit wide, input int port, input int addr);
        rd_exp_t e;
        e.wide = wide;
        e.port = port;
        e.addr = addr;
        e.exp  = wide ? m64[addr] : {32'b0, m32[addr]};
        sb.push_back(e);
    endtask

    task automatic drain();
        rd_exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.wide) begin
                rd_addr4[e.port*4 +: 4] = 4'(e.addr);
                #1;
                check($sformatf("rd4_p%0d_r%0d", e.port, e.addr), rd_data4[e.port*64 +: 64], e.exp);
            end else begin
                rd_addr[e.port*5 +: 5] = 5'(e.addr);
                #1;
                check($sformatf("rd_p%0d_r%0d", e.port, e.addr), {32'b0, rd_data[e.port*32 +: 32]}, e.exp);
            end
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a != 0) m32[a] = d;
    endtask

    task automatic wr4(input int a, input logic [63:0] d);
        wr_en4 = 1'b1; wr_addr4 = 4'(a); wr_data4 = d;
        tick();
        wr_en4 = 1'b0;
        if (a != 0) m64[a] = d;
    endtask

    initial begin
        rst = 1'b0;
        rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        pend_set = 0; pend_addr = '0; clr_req = 0;
        rd_addr4 = '0; wr_en4 = 0; wr_addr4 = '0; wr_data4 = '0;
        pend_set4 = 0; pend_addr4 = '0; clr_req4 = 0;
        for (int i = 0; i < 32; i++) m32[i] = '0;
        for (int i = 0; i < 16; i++) m64[i] = '0;
        mp = '0;

        // reset state
        repeat (2) tick();
        check("rst_busy", 64'(clr_busy), 64'd0);
        check("rst_busy4", 64'(clr_busy4), 64'd0);
        check("rst_pend", 64'(pend_vec), 64'd0);
        push_rd(0, 0, 5); push_rd(0, 1, 31); push_rd(1, 3, 15);
        drain();
        rst = 1'b1;
        tick();

        // basic write/read and r0 hardwiring
        wr(5, 32'hDEADBEEF);
        push_rd(0, 0, 5);
        drain();
        wr(0, 32'h0000_1234);
        push_rd(0, 0, 0);
        drain();

        // same-cycle read of a committing write
        rd_addr[9:5] = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp32 = 32'hA5A5A5A5;
`else
        exp32 = m32[7];
`endif
        check("bypass_r7", 64'(rd_data[63:32]), 64'(exp32));
        tick();
        m32[7] = 32'hA5A5A5A5;
        wr_addr = 5'd0; wr_data = 32'h0000_1234; rd_addr[4:0] = 5'd0;
        #1;
        check("bypass_r0", 64'(rd_data[31:0]), 64'd0);
        tick();
        wr_en = 1'b0;
        push_rd(0, 1, 7); push_rd(0, 0, 0);
        drain();

        // pending bits
        pend_set = 1'b1; pend_addr = 5'd9;
        tick();
        pend_set = 1'b0; mp[9] = 1'b1;
        check("pend_set9", 64'(pend_vec), 64'(mp));
        wr(9, 32'h0000_0099); mp[9] = 1'b0;
        check("pend_clr9", 64'(pend_vec), 64'(mp));
        pend_set = 1'b1; pend_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0077;
        tick();
        pend_set = 1'b0; wr_en = 1'b0; m32[9] = 32'h0000_0077; mp[9] = 1'b1;
        check("pend_set_wins", 64'(pend_vec), 64'(mp));
        pend_set = 1'b1; pend_addr = 5'd0;
        tick();
        check("pend_r0", 64'(pend_vec), 64'(mp));
        pend_addr = 5'd4;
        tick();
        mp[4] = 1'b1;
        pend_addr = 5'd6; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_0044;
        tick();
        pend_set = 1'b0; wr_en = 1'b0; m32[4] = 32'h0000_0044; mp[4] = 1'b0; mp[6] = 1'b1;
        check("pend_diff_addr", 64'(pend_vec), 64'(mp));
        push_rd(0, 0, 9); push_rd(0, 1, 4);
        drain();

        // bulk clear sweep
        for (int i = 1; i < 32; i++) wr(i, 32'h5A00_0000 | 32'(i * 257));
        push_rd(0, 0, 1); push_rd(0, 1, 17); push_rd(0, 0, 31);
        drain();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_busy_start", 64'(clr_busy), 64'd1);
        check("clr_pend_zero", 64'(pend_vec), 64'd0);
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            cnt++;
            wr_en = (cnt == 4); wr_addr = 5'd2; wr_data = 32'hFFFF_0000;
            clr_req = (cnt == 6);
            pend_set = (cnt == 7); pend_addr = 5'd12;
            if (cnt == 11) begin
                rd_addr[4:0] = 5'd31; rd_addr[9:5] = 5'd1;
                #1;
                check("mid_sweep_r31", 64'(rd_data[31:0]), 64'(m32[31]));
                check("mid_sweep_r1", 64'(rd_data[63:32]), 64'd0);
            end
            tick();
        end
        wr_en = 1'b0; clr_req = 1'b0; pend_set = 1'b0;
        check("clr_busy_cycles", 64'(cnt), 64'd32);
        for (int i = 0; i < 32; i++) m32[i] = '0;
        mp = '0;
        check("clr_pend_after", 64'(pend_vec), 64'(mp));
        for (int i = 0; i < 32; i++) push_rd(0, i % 2, i);
        drain();

        // asynchronous reset in the middle of a sweep
        wr(31, 32'h3131_3131); wr(3, 32'h0000_0303);
        pend_set = 1'b1; pend_addr = 5'd5;
        tick();
        pend_set = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        rd_addr[4:0] = 5'd31;
        #1;
        check("pre_rst_r31", 64'(rd_data[31:0]), 64'(m32[31]));
        #1;
        rst = 1'b0;
        #1;
        check("arst_busy", 64'(clr_busy), 64'd0);
        check("arst_pend", 64'(pend_vec), 64'd0);
        check("arst_r31", 64'(rd_data[31:0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) m32[i] = '0;
        tick();
        check("post_rst_busy", 64'(clr_busy), 64'd0);
        wr(4, 32'hCAFEF00D);
        push_rd(0, 0, 4); push_rd(0, 1, 3); push_rd(0, 1, 31);
        drain();

        // wide instance: four ports on distinct registers, then a 16-cycle clear
        for (int i = 1; i < 16; i++) wr4(i, {32'h0123_4567 ^ 32'(i), 32'(i) * 32'h0001_0001});
        push_rd(1, 0, 3); push_rd(1, 1, 7); push_rd(1, 2, 12); push_rd(1, 3, 15);
        drain();
        push_rd(1, 0, 0);
        drain();
        clr_req4 = 1'b1;
        tick();
        clr_req4 = 1'b0;
        cnt = 0;
        while (clr_busy4 && cnt < 100) begin
            cnt++;
            tick();
        end
        check("clr4_busy_cycles", 64'(cnt), 64'd16);
        for (int i = 0; i < 16; i++) m64[i] = '0;
        for (int i = 0; i < 16; i++) push_rd(1, i % 4, i);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
